// File: rtl/vx_wb_pkg.sv
// Shared constants, writeback beat layout and helpers for the writeback arbiter.
// Optional perf counters in vx_writeback_arb are enabled with VX_WB_PERF_EN.
package vx_wb_pkg;

  localparam int NUM_WB_SRCS    = 5;
  localparam int WB_SRC_ALU     = 0;
  localparam int WB_SRC_LSU     = 1;
  localparam int WB_SRC_CSR     = 2;
  localparam int WB_SRC_FPU     = 3;
  localparam int WB_SRC_GPU     = 4;

  localparam int WB_NUM_WARPS   = 4;
  localparam int WB_NUM_THREADS = 4;
  localparam int WB_NW_BITS     = $clog2(WB_NUM_WARPS);
  localparam int WB_PERF_W      = 44;

  typedef struct packed {
    logic [WB_NW_BITS-1:0]       wid;
    logic [WB_NUM_THREADS-1:0]   tmask;
    logic [31:0]                 pc;
    logic [4:0]                  rd;
    logic [WB_NUM_THREADS*32-1:0] data;
    logic                        eop;
  } wb_beat_t;

  function automatic logic [WB_PERF_W-1:0] wb_popcount(input logic [WB_NUM_THREADS-1:0] mask);
    logic [WB_PERF_W-1:0] cnt;
    cnt = {WB_PERF_W{1'b0}};
    for (int t = 0; t < WB_NUM_THREADS; t++) begin
      cnt = cnt + {{(WB_PERF_W-1){1'b0}}, mask[t]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_rr_lock_arbiter.sv
// Round-robin arbiter that locks onto a source for the duration of a multi-beat
// result; grant is one-hot (or zero) and combinational from valid.
module vx_rr_lock_arbiter #(
  parameter int NUM_REQS = 5,
  localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQS-1:0] valid,
  input  logic [NUM_REQS-1:0] eop,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx
);
  import vx_wb_pkg::*;

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
  logic [NUM_REQS-1:0] grant_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic [IDX_W-1:0]    cand_idx_s;
  logic                found_s;
  int                  cand_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQS - 1)) begin
      return {IDX_W{1'b0}};
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  // Winner selection: locked source only, else first valid at or after rr_ptr.
  always_comb begin
    grant_s    = {NUM_REQS{1'b0}};
    win_idx_s  = {IDX_W{1'b0}};
    cand_idx_s = {IDX_W{1'b0}};
    found_s    = 1'b0;
    cand_s     = 0;
    if (!reset_n) begin
      found_s = 1'b0;
    end else if (state_q == ST_LOCKED) begin
      win_idx_s = lock_idx_q;
      found_s   = valid[lock_idx_q];
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        cand_s = int'(rr_ptr_q) + k;
        if (cand_s >= NUM_REQS) begin
          cand_s = cand_s - NUM_REQS;
        end else begin
          cand_s = cand_s;
        end
        cand_idx_s = IDX_W'(cand_s);
        if (!found_s && valid[cand_idx_s]) begin
          found_s   = 1'b1;
          win_idx_s = cand_idx_s;
        end else begin
          found_s = found_s;
        end
      end
    end
    if (found_s) begin
      grant_s[win_idx_s] = 1'b1;
    end else begin
      grant_s = {NUM_REQS{1'b0}};
    end
  end

  // Lock FSM and round-robin pointer update on each fired beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (found_s) begin
          if (eop[win_idx_s]) begin
            rr_ptr_d = next_idx(win_idx_s);
          end else begin
            state_d    = ST_LOCKED;
            lock_idx_d = win_idx_s;
          end
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (found_s && eop[lock_idx_q]) begin
          state_d  = ST_UNLOCKED;
          rr_ptr_d = next_idx(lock_idx_q);
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_UNLOCKED;
      rr_ptr_q   <= {IDX_W{1'b0}};
      lock_idx_q <= {IDX_W{1'b0}};
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  assign grant     = grant_s;
  assign grant_idx = win_idx_s;

endmodule

// File: rtl/vx_writeback_arb.sv
// Merges per-unit writeback results into one registered writeback stream.
// Define VX_WB_PERF_EN to add per-source beat and thread counters.
module vx_writeback_arb
  import vx_wb_pkg::*;
#(
  parameter int NUM_REQS    = NUM_WB_SRCS,
  parameter int NUM_WARPS   = WB_NUM_WARPS,
  parameter int NUM_THREADS = WB_NUM_THREADS,
  localparam int NW_BITS    = $clog2(NUM_WARPS),
  localparam int IDX_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_REQS-1:0]               src_valid,
  output logic [NUM_REQS-1:0]               src_ready,
  input  logic [NUM_REQS*NW_BITS-1:0]       src_wid,
  input  logic [NUM_REQS*NUM_THREADS-1:0]   src_tmask,
  input  logic [NUM_REQS*32-1:0]            src_pc,
  input  logic [NUM_REQS*5-1:0]             src_rd,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0] src_data,
  input  logic [NUM_REQS-1:0]               src_eop,
  output logic                              wb_valid,
  output logic [NW_BITS-1:0]                wb_wid,
  output logic [NUM_THREADS-1:0]            wb_tmask,
  output logic [31:0]                       wb_pc,
  output logic [4:0]                        wb_rd,
  output logic [NUM_THREADS*32-1:0]         wb_data,
  output logic                              wb_eop
`ifdef VX_WB_PERF_EN
  ,
  output logic [NUM_REQS*WB_PERF_W-1:0]     perf_wb_beats,
  output logic [NUM_REQS*WB_PERF_W-1:0]     perf_wb_threads
`endif
);

  logic [NUM_REQS-1:0] grant_s;
  logic [IDX_W-1:0]    grant_idx_s;
  logic                fire_s;
  int                  sel_i_s;
  wb_beat_t            sel_s;
  wb_beat_t            wb_q, wb_d;
  logic                wb_valid_q, wb_valid_d;

  vx_rr_lock_arbiter #(
    .NUM_REQS (NUM_REQS)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .valid     (src_valid),
    .eop       (src_eop),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign src_ready = grant_s;
  assign fire_s    = |grant_s;

  // Field mux for the granted source.
  always_comb begin
    sel_i_s     = int'(grant_idx_s);
    sel_s       = {$bits(wb_beat_t){1'b0}};
    sel_s.wid   = src_wid[sel_i_s*NW_BITS +: NW_BITS];
    sel_s.tmask = src_tmask[sel_i_s*NUM_THREADS +: NUM_THREADS];
    sel_s.pc    = src_pc[sel_i_s*32 +: 32];
    sel_s.rd    = src_rd[sel_i_s*5 +: 5];
    sel_s.data  = src_data[sel_i_s*NUM_THREADS*32 +: NUM_THREADS*32];
    sel_s.eop   = src_eop[grant_idx_s];
  end

  // Capture on fire; fields hold across idle cycles.
  always_comb begin
    wb_valid_d = fire_s;
    if (fire_s) begin
      wb_d = sel_s;
    end else begin
      wb_d = wb_q;
    end
  end

  // Writeback output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid_q <= 1'b0;
      wb_q       <= {$bits(wb_beat_t){1'b0}};
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_wid   = wb_q.wid;
  assign wb_tmask = wb_q.tmask;
  assign wb_pc    = wb_q.pc;
  assign wb_rd    = wb_q.rd;
  assign wb_data  = wb_q.data;
  assign wb_eop   = wb_q.eop;

`ifdef VX_WB_PERF_EN
  logic [WB_PERF_W-1:0] perf_beats_q [NUM_REQS];
  logic [WB_PERF_W-1:0] perf_beats_d [NUM_REQS];
  logic [WB_PERF_W-1:0] perf_thr_q   [NUM_REQS];
  logic [WB_PERF_W-1:0] perf_thr_d   [NUM_REQS];

  // Per-source counters; wrap naturally at 2^44.
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant_s[i]) begin
        perf_beats_d[i] = perf_beats_q[i] + 44'd1;
        perf_thr_d[i]   = perf_thr_q[i] + wb_popcount(src_tmask[i*NUM_THREADS +: NUM_THREADS]);
      end else begin
        perf_beats_d[i] = perf_beats_q[i];
        perf_thr_d[i]   = perf_thr_q[i];
      end
    end
  end

  // Perf counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        perf_beats_q[i] <= 44'd0;
        perf_thr_q[i]   <= 44'd0;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        perf_beats_q[i] <= perf_beats_d[i];
        perf_thr_q[i]   <= perf_thr_d[i];
      end
    end
  end

  // Flatten counters onto the perf ports.
  always_comb begin
    perf_wb_beats   = {(NUM_REQS*WB_PERF_W){1'b0}};
    perf_wb_threads = {(NUM_REQS*WB_PERF_W){1'b0}};
    for (int i = 0; i < NUM_REQS; i++) begin
      perf_wb_beats[i*WB_PERF_W +: WB_PERF_W]   = perf_beats_q[i];
      perf_wb_threads[i*WB_PERF_W +: WB_PERF_W] = perf_thr_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Scoreboard bench for vx_writeback_arb: randomized sources, a queue-based
// arbitration model, and a monitor comparing every registered writeback beat.
module tb_vx_writeback_arb;

  localparam int N  = 5;
  localparam int NT = 4;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   src_valid;
  logic [N-1:0]   src_ready;
  logic [N*2-1:0] src_wid;
  logic [N*NT-1:0] src_tmask;
  logic [N*32-1:0] src_pc;
  logic [N*5-1:0] src_rd;
  logic [N*NT*32-1:0] src_data;
  logic [N-1:0]   src_eop;
  logic           wb_valid;
  logic [1:0]     wb_wid;
  logic [NT-1:0]  wb_tmask;
  logic [31:0]    wb_pc;
  logic [4:0]     wb_rd;
  logic [NT*32-1:0] wb_data;
  logic           wb_eop;
`ifdef VX_WB_PERF_EN
  logic [N*44-1:0] perf_wb_beats;
  logic [N*44-1:0] perf_wb_threads;
`endif

  vx_writeback_arb dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_wid   (src_wid),
    .src_tmask (src_tmask),
    .src_pc    (src_pc),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .src_eop   (src_eop),
    .wb_valid  (wb_valid),
    .wb_wid    (wb_wid),
    .wb_tmask  (wb_tmask),
    .wb_pc     (wb_pc),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_eop    (wb_eop)
`ifdef VX_WB_PERF_EN
    ,
    .perf_wb_beats   (perf_wb_beats),
    .perf_wb_threads (perf_wb_threads)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]     wid;
    logic [NT-1:0]  tmask;
    logic [31:0]    pc;
    logic [4:0]     rd;
    logic [NT*32-1:0] data;
    logic           eop;
    int             gap;
  } beat_t;

  beat_t  srcq [N][$];
  bit     pres [N];
  int     idle [N];
  int     prob [N];
  beat_t  expq [$];
  int     win_log [$];
  int     m_ptr;
  bit     m_lock;
  int     m_owner;
  longint m_beats [N];
  longint m_thr [N];
  beat_t  last_wb;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic beat_t mk(input logic eop, input int gap);
    beat_t b;
    b.wid   = 2'($urandom);
    b.tmask = 4'($urandom);
    b.pc    = $urandom;
    b.rd    = 5'($urandom);
    b.data  = {$urandom, $urandom, $urandom, $urandom};
    b.eop   = eop;
    b.gap   = gap;
    return b;
  endfunction

  function automatic beat_t zero_beat();
    beat_t b;
    b.wid = 2'd0; b.tmask = 4'd0; b.pc = 32'd0; b.rd = 5'd0;
    b.data = 128'd0; b.eop = 1'b0; b.gap = 0;
    return b;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: present source beats, predict the grant, record the expected beat.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int win;
    beat_t h;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && srcq[i].size() > 0) begin
        if (idle[i] >= srcq[i][0].gap && $urandom_range(99) < prob[i]) pres[i] = 1'b1;
        else idle[i]++;
      end
      if (pres[i]) begin
        h = srcq[i][0];
        src_valid[i] = 1'b1;
        src_wid[i*2 +: 2] = h.wid;
        src_tmask[i*NT +: NT] = h.tmask;
        src_pc[i*32 +: 32] = h.pc;
        src_rd[i*5 +: 5] = h.rd;
        src_data[i*NT*32 +: NT*32] = h.data;
        src_eop[i] = h.eop;
      end else begin
        src_valid[i] = 1'b0;
        src_wid[i*2 +: 2] = 2'($urandom);
        src_tmask[i*NT +: NT] = 4'($urandom);
        src_pc[i*32 +: 32] = $urandom;
        src_rd[i*5 +: 5] = 5'($urandom);
        src_data[i*NT*32 +: NT*32] = {$urandom, $urandom, $urandom, $urandom};
        src_eop[i] = 1'($urandom);
      end
    end
    #1;
    win = -1;
    if (m_lock) begin
      if (pres[m_owner]) win = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (win < 0 && pres[(m_ptr + k) % N]) win = (m_ptr + k) % N;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("src_ready", 192'(src_ready), 192'(exp_rdy));
    if (win >= 0) begin
      h = srcq[win].pop_front();
      pres[win] = 1'b0;
      idle[win] = 0;
      expq.push_back(h);
      win_log.push_back(win);
      m_beats[win]++;
      m_thr[win] += $countones(h.tmask);
      if (h.eop) begin
        m_lock = 1'b0;
        m_ptr  = (win + 1) % N;
      end else begin
        m_lock  = 1'b1;
        m_owner = win;
      end
    end
  endtask

  // Monitor: every registered beat must match the scoreboard head, idle cycles hold.
  initial begin
    beat_t e;
    last_wb = zero_beat();
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        last_wb = zero_beat();
      end else begin
        chk("wb_valid", 192'(wb_valid), 192'(expq.size() > 0));
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("wb_beat", {wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop},
                         {e.wid, e.tmask, e.pc, e.rd, e.data, e.eop});
          last_wb = e;
        end else begin
          chk("wb_hold", {wb_wid, wb_tmask, wb_pc, wb_rd, wb_data, wb_eop},
                         {last_wb.wid, last_wb.tmask, last_wb.pc, last_wb.rd, last_wb.data, last_wb.eop});
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    src_valid = '1;
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      pres[i] = 1'b0; idle[i] = 0; prob[i] = 100;
      m_beats[i] = 0; m_thr[i] = 0;
    end
    expq.delete();
    win_log.delete();
    m_ptr = 0; m_lock = 1'b0; m_owner = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_ready", 192'(src_ready), 192'(0));
      chk("rst_wb_valid", 192'(wb_valid), 192'(0));
    end
    @(negedge clk);
    reset_n = 1'b1;
    src_valid = '0;
  endtask

  task automatic drain(input int maxc);
    int c;
    c = 0;
    while (pending() && c < maxc) begin
      step();
      c++;
    end
    n_tests++;
    if (pending()) begin
      n_fail++;
      $display("FAIL drain_timeout: sources still pending after %0d cycles", maxc);
    end
    step();
  endtask

  task automatic chk_log(input string name, input int exp[]);
    chk({name, "_len"}, 192'(win_log.size()), 192'(exp.size()));
    for (int k = 0; k < exp.size() && k < win_log.size(); k++)
      chk(name, 192'(win_log[k]), 192'(exp[k]));
  endtask

`ifdef VX_WB_PERF_EN
  task automatic chk_perf();
    for (int i = 0; i < N; i++) begin
      chk("perf_beats", 192'(perf_wb_beats[i*44 +: 44]), 192'(m_beats[i][43:0]));
      chk("perf_threads", 192'(perf_wb_threads[i*44 +: 44]), 192'(m_thr[i][43:0]));
    end
  endtask
`endif

  initial begin
    int exp_fair[];
    int exp_lock[];
    int exp_wrap[];
    beat_t b;
    reset_n = 1'b0;
    src_valid = '0; src_wid = '0; src_tmask = '0; src_pc = '0;
    src_rd = '0; src_data = '0; src_eop = '0;

    // Leave a packet half-sent, then reset: the lock must be discarded.
    do_reset();
    srcq[1].push_back(mk(1'b0, 0));
    drain(20);

    // Fairness: all sources always valid with single-beat results.
    do_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 6; j++) srcq[i].push_back(mk(1'b1, 0));
    drain(100);
    exp_fair = new[30];
    foreach (exp_fair[k]) exp_fair[k] = k % N;
    chk_log("fair_order", exp_fair);

    // Lock: LSU 3-beat packet with a gap; ALU stalled until LSU eop, then CSR.
    do_reset();
    for (int j = 0; j < 4; j++) srcq[0].push_back(mk(1'b1, 0));
    srcq[1].push_back(mk(1'b0, 0));
    srcq[1].push_back(mk(1'b0, 1));
    srcq[1].push_back(mk(1'b1, 0));
    srcq[2].push_back(mk(1'b1, 0));
    drain(50);
    exp_lock = '{0, 1, 1, 1, 2, 0, 0, 0};
    chk_log("lock_order", exp_lock);

    // Wrap: FPU alone moves rr_ptr to 4, then GPU before ALU.
    do_reset();
    srcq[3].push_back(mk(1'b1, 0));
    srcq[4].push_back(mk(1'b1, 1));
    srcq[0].push_back(mk(1'b1, 1));
    drain(20);
    exp_wrap = '{3, 4, 0};
    chk_log("wrap_order", exp_wrap);

    // Sparse source: FPU only, fields checked by the scoreboard.
    do_reset();
    b = mk(1'b1, 0);
    b.wid = 2'd3; b.tmask = 4'b1010; b.rd = 5'd7;
    srcq[3].push_back(b);
    drain(20);

`ifdef VX_WB_PERF_EN
    do_reset();
    for (int j = 0; j < 10; j++) begin
      b = mk(1'b1, 0);
      b.tmask = 4'b1111;
      srcq[0].push_back(b);
    end
    drain(50);
    chk("perf_alu_beats", 192'(perf_wb_beats[43:0]), 192'(10));
    chk("perf_alu_threads", 192'(perf_wb_threads[43:0]), 192'(40));
    for (int i = 1; i < N; i++) begin
      chk("perf_other_beats", 192'(perf_wb_beats[i*44 +: 44]), 192'(0));
      chk("perf_other_threads", 192'(perf_wb_threads[i*44 +: 44]), 192'(0));
    end
`endif

    // Random traffic: multi-beat packets, random gaps and valid probabilities.
    do_reset();
    for (int i = 0; i < N; i++) begin
      prob[i] = $urandom_range(20, 100);
      for (int p = 0; p < 40; p++) begin
        int len;
        len = $urandom_range(1, 3);
        for (int j = 0; j < len; j++)
          srcq[i].push_back(mk(j == len - 1, $urandom_range(0, 3)));
      end
    end
    drain(8000);
`ifdef VX_WB_PERF_EN
    chk_perf();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
